// File: rtl/phasor_pkg.sv
// Shared types and constants for the harmonic sequencer slice.
package phasor_pkg;

  localparam int PHASE_W = 8;
  localparam int ROM_W   = 16;
  localparam int MAG_W   = 4;
  localparam int HARM_W  = 4;
  localparam int TERM_W  = 20;
  localparam int ACC_W   = 24;

  // pi * 2^60, rounded; used only to build the constant sine table
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic signed [MAG_W-1:0] sin;
    logic signed [MAG_W-1:0] cos;
  } coef_t;

  // round(32767 * sin(i*pi/128)) for i = 0..64 via a fixed-point Taylor
  // series in Q60. Only ever called with constant arguments, so it folds
  // to a table of constants.
  function automatic logic signed [ROM_W-1:0] quarter_sine(input int i);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] acc;
    logic signed [127:0] scaled;
    x    = (PI_Q60 * 128'(i)) >>> 7;
    x2   = (x * x) >>> 60;
    term = x;
    acc  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1)));
      acc  = acc + term;
    end
    scaled = (acc * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
    return scaled[ROM_W-1:0];
  endfunction

endpackage

// File: rtl/harmonic_coef_rf.sv
// Harmonic coefficient register file: entries 1..15, one write port,
// one combinational read port. Index 0 reads as zero (there is no DC term).
module harmonic_coef_rf
  import phasor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [HARM_W-1:0] wr_idx,
  input  coef_t             wr_data,
  input  logic [HARM_W-1:0] rd_idx,
  output coef_t             rd_data
);

  coef_t regs [1:15];

  // Register storage; writes to index 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 15; i++) regs[i] <= '0;
    end else if (we && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_data = '0;
    if (rd_idx != '0) rd_data = regs[rd_idx];
  end

endmodule

// File: rtl/sync_rom.sv
// Sine/cosine ROM with a registered address: data appears one cycle after
// the address is presented. Quarter-wave table folded by quadrant.
module sync_rom
  import phasor_pkg::*;
(
  input  logic                    clk,
  input  logic [PHASE_W-1:0]      addr,
  output logic signed [ROM_W-1:0] sin_out,
  output logic signed [ROM_W-1:0] cos_out
);

  logic signed [ROM_W-1:0] qtab [0:64];
  logic [PHASE_W-1:0]      addr_q;
  logic [PHASE_W-1:0]      cos_addr;

  for (genvar g = 0; g <= 64; g++) begin : g_qtab
    assign qtab[g] = quarter_sine(g);
  end

  // Mirror index within the quarter wave for quadrants 1 and 3.
  function automatic logic [6:0] fold_idx(input logic [PHASE_W-1:0] a);
    return a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

  // Address register sets the one-cycle read latency.
  always_ff @(posedge clk) begin
    addr_q <= addr;
  end

  assign cos_addr = addr_q + 8'd64;

  // Table lookup with sign taken from the upper half of the circle.
  always_comb begin
    sin_out = addr_q[7]   ? -qtab[fold_idx(addr_q)]   : qtab[fold_idx(addr_q)];
    cos_out = cos_addr[7] ? -qtab[fold_idx(cos_addr)] : qtab[fold_idx(cos_addr)];
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Additive-synthesis sample builder: walks harmonics 1..N through one shared
// sine/cosine ROM and accumulates sin*ms[k] + cos*mc[k] into a 24-bit sample.
//
// Request handshake: sample_tick is a request that is taken on any edge where
// busy is low; a tick seen while busy is dropped and answered with a one-cycle
// overrun pulse. The result is announced by a one-cycle sample_valid strobe,
// and sample_out holds its value until the next strobe.
module harmonic_sequencer
  import phasor_pkg::*;
#(
  parameter logic [PHASE_W-1:0] PHASE_STEP = 8'd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [HARM_W-1:0]       num_harm,
  input  logic                    coef_we,
  input  logic [HARM_W-1:0]       coef_idx,
  input  logic signed [MAG_W-1:0] coef_sin,
  input  logic signed [MAG_W-1:0] coef_cos,
  output logic                    busy,
  output logic                    sample_valid,
  output logic signed [ACC_W-1:0] sample_out,
  output logic                    overrun,
  output logic                    coef_wr_err
);

  seq_state_t              state, state_nxt;
  logic                    start, issue, finish;
  logic [HARM_W-1:0]       n_q, k_q;
  logic [PHASE_W-1:0]      phase_q, addr_q;
  coef_t                   wr_coef, rd_coef, cs_q;
  logic                    tv_q;
  logic signed [ROM_W-1:0] rom_sin, rom_cos;
  logic signed [TERM_W-1:0] prod_s, prod_c;
  logic signed [ACC_W-1:0] term, term_g, acc_q;

  assign wr_coef = '{sin: coef_sin, cos: coef_cos};

  harmonic_coef_rf u_coef_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (coef_we && !busy),
    .wr_idx  (coef_idx),
    .wr_data (wr_coef),
    .rd_idx  (k_q),
    .rd_data (rd_coef)
  );

  sync_rom u_rom (
    .clk     (clk),
    .addr    (addr_q),
    .sin_out (rom_sin),
    .cos_out (rom_cos)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: N=0 skips RUN; RUN ends after issuing harmonic N.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = (num_harm == '0) ? DRAIN : RUN;
      RUN:     if (k_q == n_q) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag and per-state datapath controls.
  always_comb begin
    busy   = (state != IDLE);
    start  = (state == IDLE) && sample_tick;
    issue  = (state == RUN);
    finish = (state == DRAIN);
  end

  // Term for the harmonic whose ROM data is arriving this cycle.
  always_comb begin
    prod_s = TERM_W'(rom_sin) * TERM_W'($signed(cs_q.sin));
    prod_c = TERM_W'(rom_cos) * TERM_W'($signed(cs_q.cos));
    term   = ACC_W'(prod_s) + ACC_W'(prod_c);
    term_g = tv_q ? term : '0;
  end

  // Datapath: address generation, coefficient alignment, accumulation,
  // sample register, base phase and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      n_q          <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      cs_q         <= '0;
      tv_q         <= 1'b0;
      acc_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      coef_wr_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= sample_tick && busy;
      coef_wr_err  <= coef_we && busy;
      tv_q         <= 1'b0;
      acc_q        <= acc_q + term_g;
      if (start) begin
        n_q    <= num_harm;
        k_q    <= 4'd1;
        addr_q <= phase_q;
        acc_q  <= '0;
      end
      if (issue) begin
        k_q    <= k_q + 4'd1;
        addr_q <= addr_q + phase_q;
        cs_q   <= rd_coef;
        tv_q   <= 1'b1;
      end
      if (finish) begin
        sample_out   <= acc_q + term_g;
        sample_valid <= 1'b1;
        phase_q      <= phase_q + PHASE_STEP;
      end
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Testbench for harmonic_sequencer: directed cases plus random traffic,
// checked against an arithmetic reference model through an expected queue.
module tb_harmonic_sequencer;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_tick = 1'b0;
  logic [3:0]         num_harm = '0;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_idx = '0;
  logic signed [3:0]  coef_sin = '0;
  logic signed [3:0]  coef_cos = '0;
  logic               busy;
  logic               sample_valid;
  logic signed [23:0] sample_out;
  logic               overrun;
  logic               coef_wr_err;

  harmonic_sequencer #(.PHASE_STEP(8'd1)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .num_harm     (num_harm),
    .coef_we      (coef_we),
    .coef_idx     (coef_idx),
    .coef_sin     (coef_sin),
    .coef_cos     (coef_cos),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .overrun      (overrun),
    .coef_wr_err  (coef_wr_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  int  m_p = 0;
  int  m_busy_left = 0;
  int  m_cs [1:15];
  int  m_cc [1:15];
  bit  pend_ovr = 0, pend_err = 0;
  bit  exp_busy = 0, exp_ovr = 0, exp_err = 0;
  bit  chk_en = 0;

  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];

  int total = 0;
  int bad = 0;

  function automatic int rom_val(input int a);
    real r;
    r = 32767.0 * $sin(2.0 * PI * real'(a % 256) / 256.0);
    if (r >= 0.0) return $rtoi($floor(r + 0.5));
    else          return -$rtoi($floor(-r + 0.5));
  endfunction

  function automatic int ref_sample(input int p, input int n);
    int s;
    int a;
    s = 0;
    for (int k = 1; k <= n; k++) begin
      a = (k * p) % 256;
      s += rom_val(a) * m_cs[k] + rom_val(a + 64) * m_cc[k];
    end
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input bit rst, input bit tick, input logic [3:0] n,
                       input bit we, input logic [3:0] idx,
                       input logic signed [3:0] s, input logic signed [3:0] c);
    bit busy_now;
    @(posedge clk); #1;
    reset = rst; sample_tick = tick; num_harm = n;
    coef_we = we; coef_idx = idx; coef_sin = s; coef_cos = c;
    // expectations for outputs visible during this cycle
    exp_busy = (m_busy_left > 0);
    exp_ovr  = pend_ovr;
    exp_err  = pend_err;
    pend_ovr = 0;
    pend_err = 0;
    chk_en   = 1;
    if (rst) begin
      m_p = 0;
      m_busy_left = 0;
      for (int k = 1; k <= 15; k++) begin m_cs[k] = 0; m_cc[k] = 0; end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
      end
    end else begin
      busy_now = (m_busy_left > 0);
      if (m_busy_left > 0) m_busy_left--;
      if (we) begin
        if (busy_now) pend_err = 1;
        else if (idx != 0) begin
          m_cs[int'(idx)] = int'(s);
          m_cc[int'(idx)] = int'(c);
        end
      end
      if (tick) begin
        if (busy_now) pend_ovr = 1;
        else begin
          exp_q.push_back(24'(ref_sample(m_p, int'(n))));
          exp_cyc_q.push_back(cyc + int'(n) + 2);
          m_p = (m_p + 1) % 256;
          m_busy_left = int'(n) + 1;
        end
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(0, 0, 4'd0, 0, 4'd0, 4'sd0, 4'sd0);
  endtask

  task automatic tick(input logic [3:0] n);
    cycle(0, 1, n, 0, 4'd0, 4'sd0, 4'sd0);
  endtask

  task automatic write_coef(input logic [3:0] idx, input logic signed [3:0] s,
                            input logic signed [3:0] c);
    cycle(0, 0, 4'd0, 1, idx, s, c);
  endtask

  task automatic do_reset(input int k);
    repeat (k) cycle(1, 0, 4'd0, 0, 4'd0, 4'sd0, 4'sd0);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((m_busy_left > 0 || exp_q.size() > 0) && guard < 40) begin
      idle(1);
      guard++;
    end
    idle(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [23:0] v;
    int          c;
    if (chk_en) begin
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      total++;
      if (overrun !== exp_ovr) begin
        bad++;
        $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, exp_ovr);
      end
      total++;
      if (coef_wr_err !== exp_err) begin
        bad++;
        $display("FAIL coef_wr_err cyc=%0d got=%b exp=%b", cyc, coef_wr_err, exp_err);
      end
      if (sample_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid cyc=%0d got=%0d exp=none", cyc, sample_out);
        end else begin
          v = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if (sample_out !== v || c != cyc) begin
            bad++;
            $display("FAIL sample cyc=%0d got=%0d exp=%0d exp_cyc=%0d",
                     cyc, sample_out, $signed(v), c);
          end
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        total++;
        bad++;
        v = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        $display("FAIL missing_valid cyc=%0d got=%b exp_value=%0d exp_cyc=%0d",
                 cyc, sample_valid, $signed(v), c);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 1; k <= 15; k++) begin m_cs[k] = 0; m_cc[k] = 0; end

    // reset state
    do_reset(3);
    idle(1);
    @(negedge clk);
    total++;
    if (sample_out !== 24'sd0 || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%0d/%b exp=0/0", sample_out, sample_valid);
    end

    // single cosine harmonic, three successive phases
    write_coef(4'd1, 4'sd0, 4'sd1);
    tick(4'd1);
    wait_done();
    tick(4'd1);
    wait_done();
    tick(4'd1);
    wait_done();

    // full-scale negative cosine on all 15 harmonics at p=0
    do_reset(1);
    for (int k = 1; k <= 15; k++) write_coef(4'(k), 4'sd0, -4'sd8);
    tick(4'd15);
    wait_done();

    // N=0 and back-to-back ticks landing on the valid cycle
    tick(4'd0);
    idle(1);
    tick(4'd2);
    idle(3);
    tick(4'd0);
    wait_done();

    // overrun during an N=3 sequence
    do_reset(1);
    write_coef(4'd1, 4'sd3, -4'sd2);
    write_coef(4'd2, -4'sd5, 4'sd7);
    write_coef(4'd3, 4'sd1, 4'sd4);
    tick(4'd3);
    tick(4'd3);
    wait_done();
    tick(4'd3);
    wait_done();

    // write while busy is rejected; idx 0 is silently ignored
    tick(4'd4);
    write_coef(4'd1, -4'sd8, -4'sd8);
    wait_done();
    write_coef(4'd0, 4'sd7, 4'sd7);
    tick(4'd4);
    wait_done();

    // tick and write together in IDLE: sequence sees the new coefficient
    cycle(0, 1, 4'd2, 1, 4'd2, 4'sd6, -4'sd3);
    wait_done();

    // reset in the middle of an N=10 sequence
    tick(4'd10);
    idle(3);
    do_reset(1);
    idle(2);
    tick(4'd5);
    wait_done();

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      bit               r_rst, r_tick, r_we;
      logic [3:0]       r_n, r_idx;
      logic signed [3:0] r_s, r_c;
      r_rst  = ($urandom_range(0, 349) == 0);
      r_tick = ($urandom_range(0, 99) < 30);
      r_n    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 4));
      r_we   = ($urandom_range(0, 99) < 25);
      r_idx  = 4'($urandom_range(0, 15));
      r_s    = 4'($urandom_range(0, 15));
      r_c    = 4'($urandom_range(0, 15));
      cycle(r_rst, r_tick, r_n, r_we, r_idx, r_s, r_c);
    end
    wait_done();
    idle(20);

    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL never_seen got=none exp=%0d exp_cyc=%0d",
               $signed(exp_q[0]), exp_cyc_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/harmonic_sequencer.md
# harmonic_sequencer

Time-multiplexes one shared sine/cosine ROM (`sync_rom`) across up to 15 harmonics to build one additive-synthesis sample per request. For each harmonic it computes `sin·ms[k] + cos·mc[k]` and accumulates the terms into a single 24-bit sample. It sits between the sample-rate tick source and the audio output path, replacing per-harmonic phasor instances. It also owns the harmonic coefficient register file.

## Interface
- `PHASE_STEP`, default 1: base-phase increment per completed sample (8-bit, wraps).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_tick` in 1: request one sample; accepted only when not busy.
- `num_harm` in 4: harmonic count N (0–15); sampled at tick acceptance.
- `coef_we` in 1: coefficient write strobe.
- `coef_idx` in 4: harmonic index to write (1–15).
- `coef_sin` in 4 signed: sine magnitude.
- `coef_cos` in 4 signed: cosine magnitude.
- `busy` out 1: sequence in progress.
- `sample_valid` out 1: one-cycle strobe; `sample_out` is valid while it is high.
- `sample_out` out 24 signed: accumulated sample, held until the next `sample_valid`.
- `overrun` out 1: one-cycle pulse when a tick arrives while busy.
- `coef_wr_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- **Reset values:**
  - Outputs `busy`, `sample_valid`, `overrun`, `coef_wr_err` = 0; `sample_out` = 0.
  - Internal: base phase p = 0; all coefficients = (0,0); FSM = IDLE.
- **FSM states IDLE → RUN → DRAIN → IDLE:**
  - IDLE: `sample_tick` latches N and p, then moves to RUN. If N=0, go straight to DRAIN.
  - RUN: one harmonic per cycle, k=1..N. ROM address a_k = k·p mod 256, generated incrementally (a_1=p, a_{k+1}=a_k+p, 8-bit wrap). Coefficients for k are read on the same cycle.
  - DRAIN: wait for the ROM and multiply latency, then register the final sum, pulse `sample_valid`, and set p ← p+PHASE_STEP (wraps 255→0).
- **Term and width rules:**
  - term_k = sin[a_k]·coef_sin[k] + cos[a_k]·coef_cos[k].
  - Each product is 20-bit signed; the 24-bit accumulator cannot overflow for N ≤ 15. Sign-extend every term.
  - ROM contents: sin[a] = round(32767·sin(2πa/256)); cos likewise.
- **Coefficient writes:**
  - Accepted only while `busy`=0 and `coef_idx` ≠ 0. Takes effect at the next edge.
  - A write while busy is dropped and pulses `coef_wr_err` the next cycle.
  - `coef_idx`=0 is silently ignored (no DC term).
- **Overrun:** `sample_tick` while busy is dropped and pulses `overrun` the next cycle. It does not affect p, N, or the in-flight sum.
- **Simultaneous events:**
  - Tick and write on the same IDLE cycle: the write lands and the tick is accepted. The sequence uses the new coefficient.
  - `reset` overrides everything.
- **Reset mid-sequence:** the next cycle shows `busy`=0, `sample_valid`=0 with no partial sample emitted. p and the coefficients are reinitialised.

## Timing
- Cycle 0 is the edge where `sample_tick` is sampled in IDLE.
- `busy` is high in cycles 1 through N+1.
- `sample_valid` is high only in cycle N+2, with `sample_out` updated in the same cycle. Latency is therefore N+2 cycles (N=0 → 2, N=15 → 17).
- In cycle N+2 `busy` is already 0, so a tick on that cycle is accepted. Back-to-back throughput is one sample per N+2 cycles.
- ROM read latency is 1 cycle (registered address); term-add latency is 1 cycle.

## Structure
- **Package `phasor_pkg`:**
  - Constants: PHASE_W=8, ROM_W=16, MAG_W=4, HARM_W=4, TERM_W=20, ACC_W=24.
  - `seq_state_t` enum (IDLE, RUN, DRAIN).
  - `coef_t` struct (sin, cos).
- **Sub-module `harmonic_coef_rf`:** 15×`coef_t` registers with one write port, one combinational read port and synchronous reset-to-zero.
- **Existing instance:** `sync_rom` is instantiated once.

## Test plan
- Reset; write coef[1]=(0,1); N=1; tick → `sample_valid` in cycle 3, `sample_out`=32767; `busy` high in cycles 1–2.
- Second tick after the first sample (p=1) → `sample_out`=32757; third sample (p=2) → 32728.
- All 15 coefficients = (0,−8); N=15; p=0 → `sample_valid` in cycle 17, `sample_out`=−3,932,040; no overflow.
- Tick in cycle 1 of an N=3 sequence → `overrun` pulse in cycle 2; exactly one `sample_valid` (cycle 5); next sample uses p=1.
- Write while busy → `coef_wr_err` pulse, coefficient unchanged on the next sample. Write to idx 0 → no effect, no error.
- Assert `reset` in cycle 4 of an N=10 sequence → `busy`=0 next cycle, no `sample_valid`; following tick gives a p=0 sample of 0 (coefficients cleared).
